// File: rtl/router_pkg.sv
// Shared router types: the inbound packet format and the destID -> output-port route tables.
package router_pkg;

  localparam int NPORTS   = 4;
  localparam int MAX_DEST = 5;
  localparam int PORT_W   = $clog2(NPORTS);

  typedef struct packed {
    logic [3:0]  destID;
    logic [31:0] payload;
  } pkt_t;

  function automatic logic dest_valid(input logic [3:0] dest_id);
    return dest_id <= 4'(MAX_DEST);
  endfunction

  // Only meaningful for destinations that pass dest_valid().
  function automatic logic [PORT_W-1:0] route_port(input int router_id, input logic [3:0] dest_id);
    logic [PORT_W-1:0] port;
    port = '0;
    if (router_id == 0) begin
      case (dest_id)
        4'd0:    port = 2'd0;
        4'd1:    port = 2'd2;
        4'd2:    port = 2'd3;
        default: port = 2'd1;
      endcase
    end else begin
      case (dest_id)
        4'd3:    port = 2'd0;
        4'd4:    port = 2'd1;
        4'd5:    port = 2'd2;
        default: port = 2'd3;
      endcase
    end
    return port;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: grants the first requester at or above ptr, wrapping modulo NPORTS.
module rr_pick #(
  parameter int NPORTS = 4
) (
  input  logic [NPORTS-1:0]         req,
  input  logic [$clog2(NPORTS)-1:0] ptr,
  output logic [NPORTS-1:0]         gnt,
  output logic                      any
);

  localparam int PW = $clog2(NPORTS);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = PW'((int'(ptr) + k) % NPORTS);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin output-port scheduler: routes each FIFO head, grants each free output to one
// input per cycle, and holds the output busy while its producer serialises the packet.
module rr_port_arbiter
  import router_pkg::*;
#(
  parameter int ROUTERID    = 0,
  parameter int NPORTS      = router_pkg::NPORTS,
  parameter int HOLD_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NPORTS-1:0] q_empty,
  input  pkt_t              q_head [NPORTS],
  output logic [NPORTS-1:0] deq,
  output logic [NPORTS-1:0] send_en,
  output pkt_t              send_pkt [NPORTS],
  output logic              drop_err
);

  localparam int PW = $clog2(NPORTS);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [NPORTS-1:0] bad_head;
  logic [NPORTS-1:0] req [NPORTS];
  logic [NPORTS-1:0] gnt [NPORTS];
  logic [NPORTS-1:0] out_any;
  logic [PW-1:0]     win_idx [NPORTS];
  logic [PW-1:0]     rr_ptr [NPORTS];
  logic [CW-1:0]     busy_cnt [NPORTS];

  // Each valid head requests exactly one output, so outputs arbitrate independently.
  always_comb begin
    bad_head = '0;
    for (int i = 0; i < NPORTS; i++) begin
      bad_head[i] = ~q_empty[i] && !dest_valid(q_head[i].destID);
    end
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = ~q_empty[i] && dest_valid(q_head[i].destID) &&
                    (route_port(ROUTERID, q_head[i].destID) == PORT_W'(o)) &&
                    (busy_cnt[o] == '0);
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_pick
    rr_pick #(.NPORTS(NPORTS)) u_pick (
      .req (req[o]),
      .ptr (rr_ptr[o]),
      .gnt (gnt[o]),
      .any (out_any[o])
    );
  end

  // Invalid heads are popped at once; reset suppresses any dequeue.
  always_comb begin
    deq = bad_head;
    for (int o = 0; o < NPORTS; o++) begin
      win_idx[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        if (gnt[o][i]) win_idx[o] = PW'(i);
      end
      deq = deq | gnt[o];
    end
    if (!rst_b) deq = '0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      send_en  <= '0;
      drop_err <= 1'b0;
      for (int o = 0; o < NPORTS; o++) begin
        busy_cnt[o] <= '0;
        rr_ptr[o]   <= '0;
        send_pkt[o] <= '0;
      end
    end else begin
      send_en  <= out_any;
      drop_err <= |bad_head;
      for (int o = 0; o < NPORTS; o++) begin
        if (out_any[o]) begin
          busy_cnt[o] <= CW'(HOLD_CYCLES);
          rr_ptr[o]   <= (win_idx[o] == PW'(NPORTS - 1)) ? '0 : win_idx[o] + PW'(1);
          send_pkt[o] <= q_head[win_idx[o]];
        end else if (busy_cnt[o] != '0) begin
          busy_cnt[o] <= busy_cnt[o] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed checks of rr_port_arbiter for both route tables, plus a random invariant soak.
module tb_rr_port_arbiter;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [3:0] q_empty = 4'hF;
  pkt_t       q_head [4];
  logic [3:0] deq0, send_en0, deq1, send_en1;
  pkt_t       send_pkt0 [4];
  pkt_t       send_pkt1 [4];
  logic       drop_err0, drop_err1;

  int checks = 0;
  int errors = 0;
  int ord [4] = '{0, 1, 3, 0};
  int last_en [4];

  always #5 clk = ~clk;

  rr_port_arbiter #(.ROUTERID(0), .NPORTS(4), .HOLD_CYCLES(5)) dut0 (
    .clk(clk), .rst_b(rst_b), .q_empty(q_empty), .q_head(q_head),
    .deq(deq0), .send_en(send_en0), .send_pkt(send_pkt0), .drop_err(drop_err0)
  );

  rr_port_arbiter #(.ROUTERID(1), .NPORTS(4), .HOLD_CYCLES(5)) dut1 (
    .clk(clk), .rst_b(rst_b), .q_empty(q_empty), .q_head(q_head),
    .deq(deq1), .send_en(send_en1), .send_pkt(send_pkt1), .drop_err(drop_err1)
  );

  function automatic pkt_t mkPkt(input int port, input logic [3:0] dest);
    pkt_t p;
    p.destID  = dest;
    p.payload = 32'hC0DE_0000 | (32'(port) << 8) | {28'd0, dest};
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] empty, input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
    q_empty   = empty;
    q_head[0] = mkPkt(0, d0);
    q_head[1] = mkPkt(1, d1);
    q_head[2] = mkPkt(2, d2);
    q_head[3] = mkPkt(3, d3);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_b = 1'b0;
    applyStimulus(4'hF, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    rst_b = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] exp_deq, exp_en, bad_mask;
    logic       bad_prev;
    logic [3:0] d [4];

    // Reset: outputs quiet even with non-empty heads present
    applyStimulus(4'h0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("rst_deq", 64'(deq0), 64'h0);
    checkOutput("rst_send_en", 64'(send_en0), 64'h0);
    checkOutput("rst_drop", 64'(drop_err0), 64'h0);
    checkOutput("rst_pkt", 64'(send_pkt0[0]), 64'h0);
    rst_b = 1'b1;
    applyStimulus(4'b0101, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("first_grant_deq", 64'(deq0), 64'b0010);
    tick();
    checkOutput("first_grant_en", 64'(send_en0), 64'b0001);
    checkOutput("first_grant_pkt", 64'(send_pkt0[0]), 64'(mkPkt(1, 4'd0)));
    checkOutput("busy_no_deq", 64'(deq0), 64'h0);
    rst_b = 1'b0;
    #1;
    checkOutput("midrst_en", 64'(send_en0), 64'h0);
    checkOutput("midrst_pkt", 64'(send_pkt0[0]), 64'h0);
    checkOutput("midrst_deq", 64'(deq0), 64'h0);
    rst_b = 1'b1;
    #1;
    checkOutput("post_rst_ptr0", 64'(deq0), 64'b0010);
    tick();
    checkOutput("post_rst_en", 64'(send_en0), 64'b0001);

    // Single route: input 2 dest1 -> p2 (router 0), p3 (router 1)
    doReset();
    applyStimulus(4'b1011, 4'd0, 4'd0, 4'd1, 4'd0);
    checkOutput("single_deq0", 64'(deq0), 64'b0100);
    checkOutput("single_deq1", 64'(deq1), 64'b0100);
    tick();
    checkOutput("single_en", 64'(send_en0), 64'b0100);
    checkOutput("single_pkt", 64'(send_pkt0[2]), 64'(mkPkt(2, 4'd1)));
    checkOutput("single_en_r1", 64'(send_en1), 64'b1000);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("hold_deq_%0d", k), 64'(deq0), 64'h0);
      if (k == 2) checkOutput("single_en_drop", 64'(send_en0), 64'h0);
      tick();
    end
    checkOutput("regrant_deq", 64'(deq0), 64'b0100);
    tick();
    checkOutput("regrant_en", 64'(send_en0), 64'b0100);

    // Contention on p0: grant order 0,1,3,0 every 6 cycles
    doReset();
    applyStimulus(4'b0100, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 24; c++) begin
      exp_deq = (c % 6 == 0) ? (4'b0001 << ord[c / 6]) : 4'b0000;
      exp_en  = (c % 6 == 1) ? 4'b0001 : 4'b0000;
      checkOutput($sformatf("cont_deq_c%0d", c), 64'(deq0), 64'(exp_deq));
      checkOutput($sformatf("cont_en_c%0d", c), 64'(send_en0), 64'(exp_en));
      if (c % 6 == 1)
        checkOutput($sformatf("cont_pkt_c%0d", c), 64'(send_pkt0[0]), 64'(mkPkt(ord[c / 6], 4'd0)));
      tick();
    end

    // Parallel grants under router 1; router 0 sees contention on p1
    doReset();
    applyStimulus(4'b0000, 4'd3, 4'd4, 4'd5, 4'd0);
    checkOutput("par_deq1", 64'(deq1), 64'b1111);
    checkOutput("par_deq0", 64'(deq0), 64'b1001);
    tick();
    checkOutput("par_en1", 64'(send_en1), 64'b1111);
    checkOutput("par_en0", 64'(send_en0), 64'b0011);
    checkOutput("par_pkt0", 64'(send_pkt1[0]), 64'(mkPkt(0, 4'd3)));
    checkOutput("par_pkt1", 64'(send_pkt1[1]), 64'(mkPkt(1, 4'd4)));
    checkOutput("par_pkt2", 64'(send_pkt1[2]), 64'(mkPkt(2, 4'd5)));
    checkOutput("par_pkt3", 64'(send_pkt1[3]), 64'(mkPkt(3, 4'd0)));

    // Invalid destination: dropped, no grant, pointer untouched
    doReset();
    applyStimulus(4'b1101, 4'd0, 4'd9, 4'd0, 4'd0);
    checkOutput("inv_deq", 64'(deq0), 64'b0010);
    checkOutput("inv_drop_now", 64'(drop_err0), 64'h0);
    tick();
    checkOutput("inv_drop_next", 64'(drop_err0), 64'h1);
    checkOutput("inv_no_en", 64'(send_en0), 64'h0);
    applyStimulus(4'b1111, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("inv_empty_deq", 64'(deq0), 64'h0);
    tick();
    checkOutput("inv_drop_clear", 64'(drop_err0), 64'h0);
    applyStimulus(4'b1100, 4'd3, 4'd3, 4'd0, 4'd0);
    checkOutput("inv_ptr_kept", 64'(deq0), 64'b0001);

    // Several invalid heads give a single pulse; an invalid head does not block others
    doReset();
    applyStimulus(4'b1010, 4'd9, 4'd0, 4'd10, 4'd0);
    checkOutput("multi_inv_deq", 64'(deq0), 64'b0101);
    tick();
    checkOutput("multi_inv_drop", 64'(drop_err0), 64'h1);
    applyStimulus(4'b1100, 4'd0, 4'd9, 4'd0, 4'd0);
    checkOutput("mixed_deq", 64'(deq0), 64'b0011);
    tick();
    checkOutput("mixed_drop", 64'(drop_err0), 64'h1);
    checkOutput("mixed_en", 64'(send_en0), 64'b0001);
    applyStimulus(4'b1111, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("mixed_drop_clear", 64'(drop_err0), 64'h0);

    // Random soak against the invariants
    doReset();
    for (int o = 0; o < 4; o++) last_en[o] = -100;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 7));
      applyStimulus(4'($urandom_range(0, 15)), d[0], d[1], d[2], d[3]);
      bad_mask = '0;
      for (int i = 0; i < 4; i++) bad_mask[i] = ~q_empty[i] && (d[i] > 4'd5);
      checkOutput("soak_deq_empty0", 64'(deq0 & q_empty), 64'h0);
      checkOutput("soak_deq_empty1", 64'(deq1 & q_empty), 64'h0);
      checkOutput("soak_bad_deq", 64'(deq0 & bad_mask), 64'(bad_mask));
      bad_prev = |bad_mask;
      tick();
      checkOutput("soak_drop", 64'(drop_err0), 64'(bad_prev));
      for (int o = 0; o < 4; o++) begin
        if (send_en0[o]) begin
          checkOutput($sformatf("soak_spacing_p%0d", o), 64'(cyc - last_en[o] >= 6), 64'h1);
          last_en[o] = cyc;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
